steer_lane_demux: RTL and testbench

Clocked consumer for the four-stage NCL steering ring. It accepts the ring's one-hot `steer[3:0]` DATA/NULL wavefronts and returns the `steerCOMP` completion. Each DATA wavefront routes exactly one word from a synchronous input stream into the selected one of four output lane holding registers. It forms the boundary where the ring's round-robin token drives synchronous datapath distribution.

---
 rtl/steer_lane_demux_if.sv | 27 ++
 rtl/steer_lane_demux.sv | 104 ++++++++++
 tb/tb_steer_lane_demux.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/steer_lane_demux_if.sv
// Bundle between the steering-ring consumer and its stream source, lane sinks and status.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input side, lane_valid/lane_ready per output lane.
interface steer_lane_demux_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         steer;
    logic               steer_comp;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         lane_valid;
    logic [3:0]         lane_ready;
    logic [4*WIDTH-1:0] lane_data;
    logic               onehot_err;
    logic               seq_err;

    modport master (
        output steer, in_valid, in_data, lane_ready,
        input  steer_comp, in_ready, lane_valid, lane_data, onehot_err, seq_err
    );

    modport slave (
        input  steer, in_valid, in_data, lane_ready,
        output steer_comp, in_ready, lane_valid, lane_data, onehot_err, seq_err
    );
endinterface

// File: rtl/steer_lane_demux.sv
// Routes one input word per NCL ring DATA wavefront into the selected lane register.
// Latency: steer edge to XFER/comp-fall SYNC_STAGES+1 cycles; comp rises on the transfer edge.
// Backpressure: in_ready only in XFER with the target lane empty; a full lane stalls the ring.
module steer_lane_demux #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               init_n,
    steer_lane_demux_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

    state_t             state;
    logic [3:0]         sync_q [SYNC_STAGES];
    logic [3:0]         steer_s;
    logic [1:0]         sel;
    logic [1:0]         nxt_tok;
    logic [1:0]         idx;
    logic               is_onehot;
    logic               fire;
    logic               steer_comp_q;
    logic [3:0]         lane_valid_q;
    logic [4*WIDTH-1:0] lane_data_q;
    logic               onehot_err_q;
    logic               seq_err_q;

    // Each rail gets its own flop chain; the ring is fully asynchronous to clk.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'd0;
        end else begin
            sync_q[0] <= bus.steer;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign steer_s   = sync_q[SYNC_STAGES-1];
    assign is_onehot = (steer_s != 4'd0) && ((steer_s & (steer_s - 4'd1)) == 4'd0);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (steer_s[i]) idx = 2'(i);
        end
    end

    assign bus.in_ready = (state == XFER) && !lane_valid_q[sel];
    assign fire         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state        <= IDLE;
            sel          <= 2'd0;
            nxt_tok      <= 2'd0;
            steer_comp_q <= 1'b0;
            lane_valid_q <= 4'd0;
            lane_data_q  <= '0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_valid_q[i] && bus.lane_ready[i]) lane_valid_q[i] <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (is_onehot) begin
                        sel     <= idx;
                        nxt_tok <= idx + 2'd1;
                        if (idx != nxt_tok) seq_err_q <= 1'b1;
                        state   <= XFER;
                    end else if (steer_s != 4'd0) begin
                        // Multi-hot: acknowledge so the ring is not deadlocked, but move no data.
                        onehot_err_q <= 1'b1;
                        steer_comp_q <= 1'b1;
                        state        <= ACK;
                    end
                end
                XFER: begin
                    // A fill never coincides with a drain of the same lane: in_ready needs it empty.
                    if (fire) begin
                        lane_data_q[int'(sel)*WIDTH +: WIDTH] <= bus.in_data;
                        lane_valid_q[sel] <= 1'b1;
                        steer_comp_q      <= 1'b1;
                        state             <= ACK;
                    end
                end
                ACK: begin
                    if (steer_s == 4'd0) begin
                        steer_comp_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.steer_comp = steer_comp_q;
    assign bus.lane_valid = lane_valid_q;
    assign bus.lane_data  = lane_data_q;
    assign bus.onehot_err = onehot_err_q;
    assign bus.seq_err    = seq_err_q;
endmodule

// File: tb/tb_steer_lane_demux.sv
// Directed bench for steer_lane_demux: cycle model of the ring-consumer rules plus literal checks.
module tb_steer_lane_demux;
    localparam int W    = 8;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic init_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    steer_lane_demux_if #(.WIDTH(W)) bus ();

    steer_lane_demux #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .init_n (init_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a token, 1 moving a word, 2 acknowledged awaiting NULL
    int         m_phase, m_sel, m_exp;
    bit         m_full [4];
    logic [W-1:0] m_data [4];
    bit         m_oh, m_seq;
    logic [3:0] m_pipe [SYNC];

    always @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            m_phase = 0; m_sel = 0; m_exp = 0; m_oh = 0; m_seq = 0;
            for (int i = 0; i < 4; i++) begin m_full[i] = 0; m_data[i] = '0; end
            for (int i = 0; i < SYNC; i++) m_pipe[i] = 4'd0;
        end else begin
            logic [3:0] seen;
            bit take;
            seen = m_pipe[SYNC-1];
            take = (m_phase == 1) && !m_full[m_sel] && bus.in_valid;
            for (int i = 0; i < 4; i++) if (m_full[i] && bus.lane_ready[i]) m_full[i] = 0;
            if (m_phase == 0) begin
                if ($countones(seen) == 1) begin
                    for (int i = 0; i < 4; i++) if (seen[i]) m_sel = i;
                    if (m_sel != m_exp) m_seq = 1;
                    m_exp = (m_sel + 1) % 4;
                    m_phase = 1;
                end else if ($countones(seen) > 1) begin
                    m_oh = 1;
                    m_phase = 2;
                end
            end else if (m_phase == 1) begin
                if (take) begin
                    m_data[m_sel] = bus.in_data;
                    m_full[m_sel] = 1;
                    m_phase = 2;
                end
            end else if (seen == 4'd0) begin
                m_phase = 0;
            end
            for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = bus.steer;
        end
    end

    // ---------------- compare + observation ----------------
    logic [W-1:0] obs_q [4][$];
    int  rises = 0;
    logic prev_comp = 1'b0;

    always @(negedge clk) begin
        logic [4*W-1:0] ed;
        logic [3:0] ev;
        for (int i = 0; i < 4; i++) begin
            ed[i*W +: W] = m_data[i];
            ev[i] = m_full[i];
        end
        chk("cmp_steer_comp", {31'd0, bus.steer_comp}, {31'd0, m_phase == 2});
        chk("cmp_in_ready", {31'd0, bus.in_ready}, {31'd0, (m_phase == 1) && !m_full[m_sel]});
        chk("cmp_lane_valid", {28'd0, bus.lane_valid}, {28'd0, ev});
        chk("cmp_lane_data", bus.lane_data, ed);
        chk("cmp_onehot_err", {31'd0, bus.onehot_err}, {31'd0, m_oh});
        chk("cmp_seq_err", {31'd0, bus.seq_err}, {31'd0, m_seq});
        for (int i = 0; i < 4; i++)
            if (bus.lane_valid[i] && bus.lane_ready[i]) obs_q[i].push_back(bus.lane_data[i*W +: W]);
        if (bus.steer_comp && !prev_comp) rises++;
        prev_comp = bus.steer_comp;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_comp(input logic v, input string nm);
        int n = 0;
        @(negedge clk);
        while (bus.steer_comp !== v && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, bus.steer_comp}, {31'd0, v});
    endtask

    task automatic token(input logic [3:0] t, input logic [W-1:0] d);
        @(posedge clk); #1;
        bus.steer = t; bus.in_valid = 1'b1; bus.in_data = d;
        wait_comp(1'b1, "tok_comp_rise");
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.steer = 4'd0;
        wait_comp(1'b0, "tok_comp_fall");
    endtask

    function automatic logic [W-1:0] first_obs(input int lane);
        if (obs_q[lane].size() == 0) return 'x;
        return obs_q[lane][0];
    endfunction

    task automatic clear_obs();
        for (int i = 0; i < 4; i++) obs_q[i].delete();
        rises = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; init_n = 1'b0;
        @(posedge clk); #1; init_n = 1'b1;
    endtask

    logic [W-1:0] lap1 [4];

    initial begin
        bus.steer = 4'd0; bus.in_valid = 1'b0; bus.in_data = '0; bus.lane_ready = 4'hF;
        lap1[0] = 8'h11; lap1[1] = 8'h22; lap1[2] = 8'h33; lap1[3] = 8'h44;
        repeat (2) @(negedge clk);
        chk("rst_comp", {31'd0, bus.steer_comp}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_lane_valid", {28'd0, bus.lane_valid}, 32'd0);
        chk("rst_lane_data", bus.lane_data, 32'd0);
        @(posedge clk); #1; init_n = 1'b1;

        // one lap, every lane draining immediately
        clear_obs();
        for (int i = 0; i < 4; i++) token(4'd1 << i, lap1[i]);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("lap_drain_count", obs_q[i].size(), 32'd1);
            chk("lap_drain_word", {24'd0, first_obs(i)}, {24'd0, lap1[i]});
        end
        chk("lap_rises", rises, 32'd4);
        chk("lap_onehot_err", {31'd0, bus.onehot_err}, 32'd0);
        chk("lap_seq_err", {31'd0, bus.seq_err}, 32'd0);

        // no drain: lap 1 fills all lanes, lap 2 lane 0 stalls
        @(posedge clk); #1; bus.lane_ready = 4'h0;
        clear_obs();
        token(4'b0001, 8'h55); token(4'b0010, 8'h66); token(4'b0100, 8'h77); token(4'b1000, 8'h88);
        chk("full_lanes", {28'd0, bus.lane_valid}, 32'hF);
        @(posedge clk); #1; bus.steer = 4'b0001; bus.in_valid = 1'b1; bus.in_data = 8'h99;
        repeat (8) @(negedge clk);
        chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("stall_comp", {31'd0, bus.steer_comp}, 32'd0);
        @(posedge clk); #1; bus.lane_ready = 4'b0001;
        @(posedge clk); #1; bus.lane_ready = 4'b0000;
        @(negedge clk);
        chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("drain_word", {24'd0, first_obs(0)}, 32'h55);
        @(posedge clk); @(negedge clk);
        chk("unstall_comp", {31'd0, bus.steer_comp}, 32'd1);
        chk("unstall_lane0", {24'd0, bus.lane_data[7:0]}, 32'h99);
        @(posedge clk); #1; bus.in_valid = 1'b0; bus.steer = 4'd0;
        wait_comp(1'b0, "unstall_comp_fall");
        @(posedge clk); #1; bus.lane_ready = 4'hF;
        repeat (3) @(negedge clk);

        // input starved in XFER for 10 cycles (token 1 is next in order)
        @(posedge clk); #1; bus.steer = 4'b0010; bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("starve_comp", {31'd0, bus.steer_comp}, 32'd0);
            chk("starve_lanes", {28'd0, bus.lane_valid}, 32'd0);
        end
        @(posedge clk); #1; bus.in_valid = 1'b1; bus.in_data = 8'hAA;
        @(posedge clk); @(negedge clk);
        chk("starve_comp_after", {31'd0, bus.steer_comp}, 32'd1);
        chk("starve_lane1", {24'd0, bus.lane_data[15:8]}, 32'hAA);
        @(posedge clk); #1; bus.in_valid = 1'b0; bus.steer = 4'd0;
        wait_comp(1'b0, "starve_comp_fall");

        // multi-hot wavefront
        @(posedge clk); #1; bus.steer = 4'b0101;
        wait_comp(1'b1, "mh_comp_rise");
        chk("mh_onehot_err", {31'd0, bus.onehot_err}, 32'd1);
        chk("mh_no_write", {28'd0, bus.lane_valid}, 32'd0);
        @(posedge clk); #1; bus.steer = 4'd0;
        wait_comp(1'b0, "mh_comp_fall");
        chk("mh_seq_err", {31'd0, bus.seq_err}, 32'd0);

        // out-of-order token
        pulse_reset();
        clear_obs();
        token(4'b0001, 8'hB1);
        chk("ooo_seq_before", {31'd0, bus.seq_err}, 32'd0);
        token(4'b0100, 8'hB3);
        chk("ooo_seq_set", {31'd0, bus.seq_err}, 32'd1);
        token(4'b1000, 8'hB4);
        repeat (3) @(negedge clk);
        chk("ooo_lane2_word", {24'd0, first_obs(2)}, 32'hB3);
        chk("ooo_lane1_idle", obs_q[1].size(), 32'd0);

        // reset while acknowledging with DATA still on the ring
        @(posedge clk); #1; bus.steer = 4'b0010; bus.in_valid = 1'b1; bus.in_data = 8'hC3;
        wait_comp(1'b1, "rst_ack_rise");
        @(posedge clk); #1; bus.in_valid = 1'b0;
        #2; init_n = 1'b0;
        #1;
        chk("arst_comp", {31'd0, bus.steer_comp}, 32'd0);
        chk("arst_lane_valid", {28'd0, bus.lane_valid}, 32'd0);
        chk("arst_lane_data", bus.lane_data, 32'd0);
        chk("arst_seq_err", {31'd0, bus.seq_err}, 32'd0);
        chk("arst_onehot_err", {31'd0, bus.onehot_err}, 32'd0);
        @(posedge clk); #1; init_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rearm_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rearm_seq_err", {31'd0, bus.seq_err}, 32'd1);
        chk("rearm_comp", {31'd0, bus.steer_comp}, 32'd0);
        @(posedge clk); #1; bus.in_valid = 1'b1; bus.in_data = 8'hD4;
        wait_comp(1'b1, "rearm_comp_rise");
        @(posedge clk); #1; bus.in_valid = 1'b0; bus.steer = 4'd0;
        wait_comp(1'b0, "rearm_comp_fall");

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
